delay: RTL and testbench
========================

DELAY -- requirements
Module: delay

Interface
REQ-001 Parameter DATA_W, default 8: data path width in bits, legal range 1..64.
REQ-002 Parameter DELAY_CYC, default 3: latency in clock cycles, legal range 1..64.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 iv_data  input  DATA_W  data sample, captured every rising edge (no enable).
REQ-006 ov_data  output  DATA_W  data delayed by DELAY_CYC cycles, driven directly from a register.
REQ-007 o_valid  output  1  high once the delay line holds only samples captured since the last reset.
REQ-008 There is one clock and the reset is synchronous and active-high; there are no other inputs.

Function
REQ-009 The block SHALL implement a shift chain of DELAY_CYC registers, each DATA_W wide.
- Stage 0 loads iv_data.
- Stage k loads stage k-1.
- ov_data is the last stage.
REQ-010 For rising edge n with reset low, ov_data after edge n SHALL equal the iv_data sampled at edge n-DELAY_CYC+1. This makes the latency exactly DELAY_CYC edges from capture to appearance.
REQ-011 With DELAY_CYC=1, the block SHALL behave as a single register: ov_data equals iv_data from the previous edge.
REQ-012 Data SHALL pass bit-exact, with no arithmetic, truncation or sign handling.
REQ-013 ov_data SHALL change only on rising edges of i_clk.
- No combinational path from iv_data to ov_data.
- No glitch between edges.
REQ-014 A fill counter SHALL count edges since reset deassertion and saturate at DELAY_CYC.
- o_valid = 1 when counter == DELAY_CYC, else 0.
- The counter width is ceil(log2(DELAY_CYC+1)) bits.
- The counter SHALL not wrap.
REQ-015 The first nonzero-reset sample SHALL appear on ov_data on the same edge that o_valid rises.
REQ-016 A constant iv_data value held for at least DELAY_CYC cycles SHALL appear as a constant on ov_data.

Reset
REQ-017 At a rising edge with i_rst=1, all stages SHALL load 0.
- ov_data = 0 and o_valid = 0 after that edge.
- The fill counter = 0 after that edge.
REQ-018 Reset SHALL dominate data: the iv_data value present at a reset edge is discarded.
REQ-019 Reset asserted mid-stream SHALL flush the chain.
- Samples captured before the reset edge never appear on ov_data afterwards.
- ov_data stays 0 until new data propagates through.
REQ-020 After reset deasserts, the first edge with i_rst=0 SHALL capture iv_data into stage 0.
- That sample appears on ov_data DELAY_CYC-1 edges later.
- o_valid rises on that same edge.
REQ-021 Before the first reset edge, output values are undefined; the bench SHALL apply reset for at least 1 cycle.

Verification
REQ-022 Reset held 2 cycles with iv_data=8'hA5 -> ov_data=8'h00 and o_valid=0 throughout; the value A5 never emerges.
REQ-023 Default params, ramp iv_data=0..15 one per cycle after reset -> ov_data reproduces 0..15 in order.
- Offset is exactly 3 cycles.
- o_valid rises with the first value.
- The final value 15 holds after the input stops changing.
REQ-024 Single-cycle pulse iv_data=8'hFF in a stream of zeros -> exactly one cycle of ov_data=8'hFF, 3 cycles later.
REQ-025 Reset asserted for 1 cycle mid-ramp, at input value 7 -> ov_data drops to 0 with o_valid=0.
- Values 5, 6 and 7 are lost.
- Post-reset values appear again after 3 cycles.
REQ-026 Parameter sweep DELAY_CYC=1 and DELAY_CYC=8 with DATA_W=16, using random data -> a reference queue model matches every cycle, including o_valid timing.
REQ-027 The bench SHALL check every edge against a cycle-accurate model and report the first mismatch with time, input and output values.

Source files
------------

// File: rtl/delay.sv
// -----------------------------------------------------------------------------
// delay
//
// Fixed-latency pipeline delay line. Every rising edge of i_clk captures
// iv_data into the first stage of a DELAY_CYC-deep register chain. The last
// stage drives ov_data, so a sample captured on edge n is visible on ov_data
// after edge n+DELAY_CYC-1.
//
// A saturating fill counter tracks how many edges have passed since reset
// deasserted. o_valid is asserted once every stage holds post-reset data.
//
// Parameters
//   DATA_W     data path width in bits       (1..64)
//   DELAY_CYC  depth of the register chain   (1..64)
//
// Ports
//   i_clk    in   1        sole clock, rising edge
//   i_rst    in   1        synchronous active-high reset, clears chain/counter
//   iv_data  in   DATA_W   sample captured on every rising edge
//   ov_data  out  DATA_W   sample delayed by DELAY_CYC cycles (registered)
//   o_valid  out  1        chain holds only samples captured since reset
// -----------------------------------------------------------------------------
module delay #(
   parameter int DATA_W    = 8,
   parameter int DELAY_CYC = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] iv_data,
   output logic [DATA_W-1:0] ov_data,
   output logic              o_valid
);

   // Enough bits to hold the value DELAY_CYC itself, where the count stops.
   localparam int CNT_W = $clog2(DELAY_CYC + 1);
   localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(DELAY_CYC);

   logic [DATA_W-1:0] stage_q [DELAY_CYC];
   logic [CNT_W-1:0]  fill_q;

   // ---------------------------------------------------------------------------
   // Shift chain
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // stage samples its predecessor's value from before the edge; blocking
   // assignments here would collapse the chain into a single register.
   //
   // NOTE: unlike a RAM, every stage of this chain is cleared on reset. A
   // flushed sample must never reappear on ov_data, and the zero fill is what
   // ov_data shows while the chain refills.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < DELAY_CYC; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q[0] <= iv_data;
         for (int k = 1; k < DELAY_CYC; k++) begin
            stage_q[k] <= stage_q[k-1];
         end
      end
   end

   // The output is the last stage itself: no logic sits between the register
   // and the port, so ov_data only moves on a clock edge.
   assign ov_data = stage_q[DELAY_CYC-1];

   // ---------------------------------------------------------------------------
   // Fill counter
   // ---------------------------------------------------------------------------
   // Counts edges since reset and holds at DELAY_CYC. It reaches DELAY_CYC on
   // the same edge that the first post-reset sample lands in the last stage,
   // so o_valid and that sample appear together.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fill_q <= '0;
      end else if (fill_q != FILL_FULL) begin
         fill_q <= fill_q + CNT_W'(1);
      end
   end

   assign o_valid = (fill_q == FILL_FULL);

endmodule

// File: tb/tb_delay.sv
// -----------------------------------------------------------------------------
// tb_delay
//
// Three instances of delay share clock and reset:
//   dut_a : default parameters (DATA_W=8,  DELAY_CYC=3), directed stimulus
//   dut_b : DATA_W=16, DELAY_CYC=1, random data
//   dut_c : DATA_W=16, DELAY_CYC=8, random data
//
// The stimulus process drives inputs on the falling edge and, right after the
// following rising edge, pushes the expected output of each instance into a
// queue. Expectations come from a history-based reference model (every
// instance) and, for dut_a, also from hand-computed directed vectors. A
// separate monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_delay;

   typedef struct {
      logic [15:0] din;
      logic [15:0] data;
      logic        valid;
   } exp_t;

   localparam int D_A = 3;
   localparam int D_B = 1;
   localparam int D_C = 8;

   logic        i_clk;
   logic        i_rst;
   logic [7:0]  din_a;
   logic [15:0] din_b;
   logic [15:0] din_c;
   logic [7:0]  ov_a;
   logic [15:0] ov_b;
   logic [15:0] ov_c;
   logic        val_a;
   logic        val_b;
   logic        val_c;

   int checks = 0;
   int errors = 0;

   exp_t q_dir[$];
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   // Sample history since the last reset edge, one per instance.
   logic [15:0] hist [3][256];
   int          hlen [3];

   delay dut_a (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .iv_data(din_a),
      .ov_data(ov_a),
      .o_valid(val_a)
   );

   delay #(.DATA_W(16), .DELAY_CYC(D_B)) dut_b (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .iv_data(din_b),
      .ov_data(ov_b),
      .o_valid(val_b)
   );

   delay #(.DATA_W(16), .DELAY_CYC(D_C)) dut_c (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .iv_data(din_c),
      .ov_data(ov_c),
      .o_valid(val_c)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // ---------------------------------------------------------------------------
   // Comparison helper
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input exp_t e,
                        input logic [15:0] got_d, input logic got_v);
      checks++;
      if (got_d !== e.data || got_v !== e.valid) begin
         errors++;
         $display("FAIL %s t=%0t in=%h got data=%h valid=%b expected data=%h valid=%b",
                  name, $time, e.din, got_d, got_v, e.data, e.valid);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: the output after an edge is the sample taken D edges
   // back in the post-reset history (counting the current edge), or zero while
   // fewer than D samples exist.
   // ---------------------------------------------------------------------------
   function automatic exp_t model_edge(input int k, input int d,
                                       input logic rst, input logic [15:0] din);
      exp_t e;
      if (rst) begin
         hlen[k] = 0;
      end else begin
         if (hlen[k] < 256) begin
            hist[k][hlen[k]] = din;
            hlen[k]++;
         end
      end
      e.din   = din;
      e.valid = (hlen[k] >= d);
      e.data  = e.valid ? hist[k][hlen[k]-d] : 16'h0000;
      return e;
   endfunction

   // ---------------------------------------------------------------------------
   // One clock of stimulus. For dut_a a directed expectation may be supplied.
   // ---------------------------------------------------------------------------
   task automatic step(input logic rst, input logic [7:0] da,
                       input logic has_dir, input logic [7:0] exp_d,
                       input logic exp_v);
      exp_t e;
      @(negedge i_clk);
      i_rst = rst;
      din_a = da;
      din_b = 16'($urandom_range(0, 65535));
      din_c = 16'($urandom_range(0, 65535));
      @(posedge i_clk);
      q_a.push_back(model_edge(0, D_A, rst, {8'h00, din_a}));
      q_b.push_back(model_edge(1, D_B, rst, din_b));
      q_c.push_back(model_edge(2, D_C, rst, din_c));
      if (has_dir) begin
         e.din   = {8'h00, da};
         e.data  = {8'h00, exp_d};
         e.valid = exp_v;
         q_dir.push_back(e);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: compares every presented output against the queued expectation.
   // ---------------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (q_dir.size() > 0) begin
            e = q_dir.pop_front();
            check("a_directed", e, {8'h00, ov_a}, val_a);
         end
         if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_model", e, {8'h00, ov_a}, val_a);
         end
         if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b_model_d1", e, ov_b, val_b);
         end
         if (q_c.size() > 0) begin
            e = q_c.pop_front();
            check("c_model_d8", e, ov_c, val_c);
         end
      end
   end

   // Hard stop in case the stimulus itself stalls.
   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got no completion required completion", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [7:0] pulse_in  [8] = '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
      logic [7:0] pulse_out [8] = '{8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
      logic [7:0] post_out  [5] = '{8'h00, 8'h00, 8'h08, 8'h09, 8'h0A};
      logic       post_val  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int         wait_cyc;

      i_rst = 1'b1;
      din_a = 8'hA5;
      din_b = 16'h0000;
      din_c = 16'h0000;
      for (int k = 0; k < 3; k++) hlen[k] = 0;

      // Reset held two cycles with A5 on the input: output stays 0, invalid.
      step(1'b1, 8'hA5, 1'b1, 8'h00, 1'b0);
      step(1'b1, 8'hA5, 1'b1, 8'h00, 1'b0);

      // Ramp 0..15: sample i emerges two edges after its capture edge,
      // together with o_valid on the third post-reset edge.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'(i), 1'b1, (i >= 2) ? 8'(i - 2) : 8'h00, (i >= 2));
      end
      // Input frozen at 15: the tail of the ramp drains and 15 holds.
      step(1'b0, 8'h0F, 1'b1, 8'h0E, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h0F, 1'b1, 8'h0F, 1'b1);

      // Single-cycle FF pulse in a stream of zeros.
      for (int i = 0; i < 8; i++) begin
         step(1'b0, pulse_in[i], 1'b1, pulse_out[i], 1'b1);
      end

      // Ramp 0..6, then reset on the edge where the input is 7.
      for (int v = 0; v < 7; v++) begin
         step(1'b0, 8'(v), 1'b1, (v >= 2) ? 8'(v - 2) : 8'h00, 1'b1);
      end
      step(1'b1, 8'h07, 1'b1, 8'h00, 1'b0);
      // Resume at 8: 5, 6 and 7 never emerge; 8 shows up with o_valid.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 8'(8 + i), 1'b1, post_out[i], post_val[i]);
      end

      // Random phase: model-only checking on all three instances, with one
      // mid-stream reset to flush the deep chain.
      for (int i = 0; i < 80; i++) begin
         step((i == 40), 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0);
      end

      // Let the monitor drain the queues, bounded.
      wait_cyc = 0;
      while ((q_dir.size() + q_a.size() + q_b.size() + q_c.size()) != 0 && wait_cyc < 10) begin
         @(negedge i_clk);
         wait_cyc++;
      end
      @(posedge i_clk);
      if ((q_dir.size() + q_a.size() + q_b.size() + q_c.size()) != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending entries required 0",
                  q_dir.size() + q_a.size() + q_b.size() + q_c.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
